// File: rtl/m_dram_arb.sv
// Round-robin arbiter that serialises per-hart load/store command pulses onto a single DRAM port.
// Optional per-requester grant counters are built when DRAM_ARB_STATS_EN is defined.
module m_dram_arb #(
    parameter int unsigned NREQ = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [32*NREQ-1:0]   w_req_addr,
    input  logic [32*NREQ-1:0]   w_req_wdata,
    input  logic [3*NREQ-1:0]    w_req_ctrl,
    input  logic [NREQ-1:0]      w_req_we,
    input  logic [NREQ-1:0]      w_req_le,
    output logic [NREQ-1:0]      w_req_busy,
    output logic [NREQ-1:0]      w_rsp_valid,
    output logic [32*NREQ-1:0]   w_rsp_odata,
    output logic [31:0]          w_dram_addr,
    output logic [31:0]          w_dram_wdata,
    output logic [2:0]           w_dram_ctrl,
    output logic                 w_dram_we_t,
    output logic                 w_dram_le,
    input  logic [31:0]          w_dram_odata,
    input  logic                 w_dram_busy,
    output logic [32*NREQ-1:0]   w_grant_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   w_grant_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   w_rr_nxt;
    logic            w_found;
    logic            w_grant_go;
    logic            w_done_go;
    logic [31:0]     w_cand;

    logic [NREQ-1:0] r_pending;
    logic [NREQ-1:0] r_busy;
    logic [NREQ-1:0] r_slot_store;
    logic [31:0]     r_slot_addr  [NREQ];
    logic [31:0]     r_slot_wdata [NREQ];
    logic [2:0]      r_slot_ctrl  [NREQ];

    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_odata  [NREQ];
    logic [31:0]     r_dram_addr;
    logic [31:0]     r_dram_wdata;
    logic [2:0]      r_dram_ctrl;
    logic            r_dram_we_t;
    logic            r_dram_le;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus round-robin search starting at r_rr
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_found     = 1'b0;
        w_grant_go  = 1'b0;
        w_done_go   = 1'b0;
        w_cand      = 32'd0;
        w_rr_nxt    = r_rr;

        for (int k = 0; k < int'(NREQ); k++) begin
            w_cand = 32'(r_rr) + 32'(k);
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_found && r_pending[w_cand[IW-1:0]]) begin
                w_found     = 1'b1;
                w_grant_nxt = w_cand[IW-1:0];
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_found && !w_dram_busy) begin
                    w_state_nxt = S_ISSUE;
                    w_grant_go  = 1'b1;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_dram_busy) begin
                    w_state_nxt = S_DONE;
                    w_done_go   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (!w_grant_go) begin
            w_grant_nxt = r_grant;
        end else if (32'(w_grant_nxt) + 32'd1 >= NREQ) begin
            w_rr_nxt = IW'(0);
        end else begin
            w_rr_nxt = IW'(32'(w_grant_nxt) + 32'd1);
        end
    end

    // Command capture, DRAM issue and response datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_grant      <= '0;
            r_rr         <= '0;
            r_pending    <= '0;
            r_busy       <= '0;
            r_slot_store <= '0;
            r_rsp_valid  <= '0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_dram_ctrl  <= '0;
            r_dram_we_t  <= 1'b0;
            r_dram_le    <= 1'b0;
            for (int i = 0; i < int'(NREQ); i++) begin
                r_slot_addr[i]  <= '0;
                r_slot_wdata[i] <= '0;
                r_slot_ctrl[i]  <= '0;
                r_rsp_odata[i]  <= '0;
            end
        end else begin
            r_dram_we_t <= 1'b0;
            r_dram_le   <= 1'b0;
            r_rsp_valid <= '0;

            // Pulses while a command is outstanding are dropped
            for (int i = 0; i < int'(NREQ); i++) begin
                if ((w_req_we[i] || w_req_le[i]) && !r_busy[i]) begin
                    r_pending[i]    <= 1'b1;
                    r_busy[i]       <= 1'b1;
                    r_slot_store[i] <= w_req_we[i];
                    r_slot_addr[i]  <= w_req_addr[32*i +: 32];
                    r_slot_wdata[i] <= w_req_wdata[32*i +: 32];
                    r_slot_ctrl[i]  <= w_req_ctrl[3*i +: 3];
                end
            end

            if (w_grant_go) begin
                r_grant                <= w_grant_nxt;
                r_rr                   <= w_rr_nxt;
                r_pending[w_grant_nxt] <= 1'b0;
                r_dram_addr            <= r_slot_addr[w_grant_nxt];
                r_dram_wdata           <= r_slot_wdata[w_grant_nxt];
                r_dram_ctrl            <= r_slot_ctrl[w_grant_nxt];
                r_dram_we_t            <= r_slot_store[w_grant_nxt];
                r_dram_le              <= !r_slot_store[w_grant_nxt];
            end

            if (w_done_go) begin
                r_rsp_valid[r_grant] <= 1'b1;
                if (!r_slot_store[r_grant]) begin
                    r_rsp_odata[r_grant] <= w_dram_odata;
                end
            end

            if (r_state == S_DONE) begin
                r_busy[r_grant] <= 1'b0;
            end
        end
    end

    assign w_req_busy   = r_busy;
    assign w_rsp_valid  = r_rsp_valid;
    assign w_dram_addr  = r_dram_addr;
    assign w_dram_wdata = r_dram_wdata;
    assign w_dram_ctrl  = r_dram_ctrl;
    assign w_dram_we_t  = r_dram_we_t;
    assign w_dram_le    = r_dram_le;

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_odata
        assign w_rsp_odata[32*g +: 32] = r_rsp_odata[g];
    end

`ifdef DRAM_ARB_STATS_EN
    logic [31:0] r_grant_cnt [NREQ];

    // Grant counters wrap naturally at 32 bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_grant_go) begin
            r_grant_cnt[w_grant_nxt] <= r_grant_cnt[w_grant_nxt] + 32'd1;
        end
    end

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt
        assign w_grant_cnt[32*g +: 32] = r_grant_cnt[g];
    end
`else
    assign w_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_m_dram_arb.sv
// Directed bench for m_dram_arb with a small behavioural DRAM model and transaction monitors.
module tb_m_dram_arb;

    localparam int unsigned NREQ = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [32*NREQ-1:0]   w_req_addr;
    logic [32*NREQ-1:0]   w_req_wdata;
    logic [3*NREQ-1:0]    w_req_ctrl;
    logic [NREQ-1:0]      w_req_we;
    logic [NREQ-1:0]      w_req_le;
    logic [NREQ-1:0]      w_req_busy;
    logic [NREQ-1:0]      w_rsp_valid;
    logic [32*NREQ-1:0]   w_rsp_odata;
    logic [31:0]          w_dram_addr;
    logic [31:0]          w_dram_wdata;
    logic [2:0]           w_dram_ctrl;
    logic                 w_dram_we_t;
    logic                 w_dram_le;
    logic [31:0]          w_dram_odata;
    logic                 w_dram_busy;
    logic [32*NREQ-1:0]   w_grant_cnt;

    m_dram_arb #(.NREQ(NREQ)) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .w_req_addr   (w_req_addr),
        .w_req_wdata  (w_req_wdata),
        .w_req_ctrl   (w_req_ctrl),
        .w_req_we     (w_req_we),
        .w_req_le     (w_req_le),
        .w_req_busy   (w_req_busy),
        .w_rsp_valid  (w_rsp_valid),
        .w_rsp_odata  (w_rsp_odata),
        .w_dram_addr  (w_dram_addr),
        .w_dram_wdata (w_dram_wdata),
        .w_dram_ctrl  (w_dram_ctrl),
        .w_dram_we_t  (w_dram_we_t),
        .w_dram_le    (w_dram_le),
        .w_dram_odata (w_dram_odata),
        .w_dram_busy  (w_dram_busy),
        .w_grant_cnt  (w_grant_cnt)
    );

    always #5 CLK = ~CLK;

    // DRAM model: busy rises the cycle after a command and stays high dram_lat cycles
    logic        dram_busy = 1'b0;
    logic [31:0] dram_rdata = 32'd0;
    int          dram_lat = 0;
    int          dcnt = 0;

    always @(posedge CLK) begin
        if (w_dram_le || w_dram_we_t) begin
            if (dram_lat > 0) begin
                dram_busy <= 1'b1;
                dcnt      <= dram_lat;
            end
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt      <= 0;
            dram_busy <= 1'b0;
        end
    end

    assign w_dram_busy  = dram_busy;
    assign w_dram_odata = dram_rdata;

    typedef struct {
        bit          store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
    } dtx_t;

    dtx_t dlog[$];
    int   rsp_log[$];
    int   rsp_cnt [NREQ];

    initial begin
        for (int i = 0; i < int'(NREQ); i++) rsp_cnt[i] = 0;
    end

    always @(negedge CLK) begin
        dtx_t t;
        if (w_dram_le || w_dram_we_t) begin
            t.store = w_dram_we_t;
            t.addr  = w_dram_addr;
            t.wdata = w_dram_wdata;
            t.ctrl  = w_dram_ctrl;
            dlog.push_back(t);
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_rsp_valid[i]) begin
                rsp_log.push_back(i);
                rsp_cnt[i] = rsp_cnt[i] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input int i, input bit we, input bit le, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
        w_req_addr[32*i +: 32]  = a;
        w_req_wdata[32*i +: 32] = d;
        w_req_ctrl[3*i +: 3]    = c;
        w_req_we[i]             = we;
        w_req_le[i]             = le;
    endtask

    task automatic clear_pulses();
        w_req_we = '0;
        w_req_le = '0;
    endtask

    task automatic wait_rsp(input int idx, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            cyc++;
            if (w_rsp_valid[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          idx;
        bit          we;
        bit          le;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
        int          lat;
        bit          exp_store;
        logic [31:0] exp_odata;
        int          exp_cyc;
    } vec_t;

    vec_t vt [6];

    initial begin
        int          cyc;
        bit          ok;
        int          snap0;
        int          snap1;
        int          oth;
        int          sent;
        logic [1:0]  rp;
        int          exp_seq [8];
        logic [31:0] cnt0;
        logic [31:0] cnt1;

        // idx, we, le, addr, wdata, ctrl, rdata, lat, exp_store, exp_odata, exp_cyc (= 3 + lat)
        vt[0] = '{0, 1'b0, 1'b1, 32'h8000_1000, 32'h0,         3'd2, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 6};
        vt[1] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0011, 3'd0, 32'h9999_9999, 0, 1'b1, 32'h0,          3};
        vt[2] = '{1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         3'd4, 32'h1234_5678, 1, 1'b0, 32'h1234_5678, 4};
        vt[3] = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 3'd1, 32'h0,         2, 1'b1, 32'hDEAD_BEEF, 5};
        vt[4] = '{1, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0055, 3'd2, 32'h0,         0, 1'b1, 32'h1234_5678, 3};
        vt[5] = '{0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         3'd0, 32'hA5A5_A5A5, 0, 1'b0, 32'hA5A5_A5A5, 3};

        RST         = 1'b1;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_ctrl  = '0;
        clear_pulses();
        repeat (3) tick();

        chk("rst_req_busy",  32'(w_req_busy), 32'd0);
        chk("rst_rsp_valid", 32'(w_rsp_valid), 32'd0);
        chk("rst_dram_cmd",  32'({w_dram_we_t, w_dram_le}), 32'd0);
        chk("rst_dram_addr", w_dram_addr, 32'd0);
        chk("rst_dram_wdata", w_dram_wdata, 32'd0);
        chk("rst_dram_ctrl", 32'(w_dram_ctrl), 32'd0);
        chk("rst_odata0",    w_rsp_odata[31:0], 32'd0);
        chk("rst_odata1",    w_rsp_odata[63:32], 32'd0);
        chk("rst_cnt0",      w_grant_cnt[31:0], 32'd0);
        chk("rst_cnt1",      w_grant_cnt[63:32], 32'd0);
        RST = 1'b0;
        tick();

        // Single-requester transactions from the table
        for (int v = 0; v < 6; v++) begin
            oth = 1 - vt[v].idx;
            dram_lat   = vt[v].lat;
            dram_rdata = vt[v].rdata;
            dlog.delete();
            snap1 = rsp_cnt[oth];
            pulse(vt[v].idx, vt[v].we, vt[v].le, vt[v].addr, vt[v].wdata, vt[v].ctrl);
            tick();
            clear_pulses();
            chk($sformatf("v%0d_busy_set", v), 32'(w_req_busy[vt[v].idx]), 32'd1);
            wait_rsp(vt[v].idx, cyc, ok);
            chk($sformatf("v%0d_rsp_seen", v), 32'(ok), 32'd1);
            chk($sformatf("v%0d_latency", v), 32'(cyc), 32'(vt[v].exp_cyc));
            chk($sformatf("v%0d_odata", v), w_rsp_odata[32*vt[v].idx +: 32], vt[v].exp_odata);
            chk($sformatf("v%0d_busy_at_rsp", v), 32'(w_req_busy[vt[v].idx]), 32'd1);
            chk($sformatf("v%0d_other_busy", v), 32'(w_req_busy[oth]), 32'd0);
            tick();
            chk($sformatf("v%0d_busy_clr", v), 32'(w_req_busy[vt[v].idx]), 32'd0);
            chk($sformatf("v%0d_rsp_one_cycle", v), 32'(w_rsp_valid), 32'd0);
            chk($sformatf("v%0d_dram_cnt", v), 32'(dlog.size()), 32'd1);
            if (dlog.size() >= 1) begin
                chk($sformatf("v%0d_dram_kind", v), 32'(dlog[0].store), 32'(vt[v].exp_store));
                chk($sformatf("v%0d_dram_addr", v), dlog[0].addr, vt[v].addr);
                chk($sformatf("v%0d_dram_ctrl", v), 32'(dlog[0].ctrl), 32'(vt[v].ctrl));
                if (vt[v].exp_store) chk($sformatf("v%0d_dram_wdata", v), dlog[0].wdata, vt[v].wdata);
            end
            chk($sformatf("v%0d_other_rsp", v), 32'(rsp_cnt[oth] - snap1), 32'd0);
            chk($sformatf("v%0d_dram_hold", v), w_dram_addr, vt[v].addr);
            repeat (2) tick();
        end

        // Reset while the arbiter waits on a long DRAM access
        dram_lat   = 10;
        dram_rdata = 32'h1111_2222;
        dlog.delete();
        snap0 = rsp_cnt[0];
        pulse(0, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 3'd2);
        tick();
        clear_pulses();
        repeat (3) tick();
        RST = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(w_req_busy), 32'd0);
        chk("mid_rst_rsp", 32'(w_rsp_valid), 32'd0);
        chk("mid_rst_addr", w_dram_addr, 32'd0);
        chk("mid_rst_ctrl", 32'(w_dram_ctrl), 32'd0);
        chk("mid_rst_odata0", w_rsp_odata[31:0], 32'd0);
        RST = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (!w_dram_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_rst_dram_idle", 32'(ok), 32'd1);
        tick();
        chk("mid_rst_no_rsp", 32'(rsp_cnt[0] - snap0), 32'd0);
        dram_lat   = 1;
        dram_rdata = 32'hBEEF_0001;
        pulse(0, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 3'd2);
        tick();
        clear_pulses();
        wait_rsp(0, cyc, ok);
        chk("post_rst_rsp", 32'(ok), 32'd1);
        chk("post_rst_odata", w_rsp_odata[31:0], 32'hBEEF_0001);
        tick();
        chk("post_rst_dram_cnt", 32'(dlog.size()), 32'd2);
        if (dlog.size() >= 2) chk("post_rst_dram_addr", dlog[1].addr, 32'h0000_0304);

        // Simultaneous store from 0 and load from 1, rr freshly reset
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        dram_lat   = 1;
        dram_rdata = 32'h0000_0077;
        dlog.delete();
        rsp_log.delete();
        pulse(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0011, 3'd0);
        pulse(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 3'd2);
        tick();
        clear_pulses();
        for (int n = 0; n < 40 && rsp_log.size() < 2; n++) tick();
        tick();
        chk("sim_rsp_cnt", 32'(rsp_log.size()), 32'd2);
        chk("sim_dram_cnt", 32'(dlog.size()), 32'd2);
        if (rsp_log.size() >= 2) begin
            chk("sim_rsp_first", 32'(rsp_log[0]), 32'd0);
            chk("sim_rsp_second", 32'(rsp_log[1]), 32'd1);
        end
        if (dlog.size() >= 2) begin
            chk("sim_tx0_store", 32'(dlog[0].store), 32'd1);
            chk("sim_tx0_addr", dlog[0].addr, 32'h0000_0100);
            chk("sim_tx0_wdata", dlog[0].wdata, 32'h0000_0011);
            chk("sim_tx1_store", 32'(dlog[1].store), 32'd0);
            chk("sim_tx1_addr", dlog[1].addr, 32'h0000_0200);
        end
        chk("sim_odata1", w_rsp_odata[63:32], 32'h0000_0077);
        cnt0 = w_grant_cnt[31:0];
        cnt1 = w_grant_cnt[63:32];
`ifdef DRAM_ARB_STATS_EN
        chk("sim_cnt0", cnt0, 32'd1);
        chk("sim_cnt1", cnt1, 32'd1);
`else
        chk("sim_cnt0_tied", cnt0, 32'd0);
        chk("sim_cnt1_tied", cnt1, 32'd0);
`endif

        // Fairness: both requesters re-pulse right after each response
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        dlog.delete();
        rsp_log.delete();
        dram_lat = 1;
        pulse(0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 3'd2);
        pulse(1, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 3'd2);
        tick();
        clear_pulses();
        sent = 2;
        for (int c = 0; c < 300 && rsp_log.size() < 8; c++) begin
            rp = '0;
            for (int i = 0; i < 2; i++) begin
                if (w_rsp_valid[i] && sent < 8) begin
                    rp[i] = 1'b1;
                    sent++;
                end
            end
            tick();
            if (rp != 2'b00) begin
                if (rp[0]) pulse(0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 3'd2);
                if (rp[1]) pulse(1, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 3'd2);
                tick();
                clear_pulses();
            end
        end
        repeat (4) tick();
        chk("fair_rsp_cnt", 32'(rsp_log.size()), 32'd8);
        chk("fair_dram_cnt", 32'(dlog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < dlog.size())
                chk($sformatf("fair_grant%0d_addr", k), dlog[k].addr,
                    (exp_seq[k] == 0) ? 32'h0000_1000 : 32'h0000_2000);
            if (k < rsp_log.size())
                chk($sformatf("fair_rsp%0d_idx", k), 32'(rsp_log[k]), 32'(exp_seq[k]));
        end
`ifdef DRAM_ARB_STATS_EN
        chk("fair_cnt0", w_grant_cnt[31:0] - cnt0, 32'd4);
        chk("fair_cnt1", w_grant_cnt[63:32] - cnt1, 32'd4);
`else
        chk("fair_cnt_tied", w_grant_cnt[31:0] | w_grant_cnt[63:32], 32'd0);
`endif

        // Protocol violation: second pulse from requester 1 while it is in flight
        dlog.delete();
        snap1 = rsp_cnt[1];
        dram_lat   = 4;
        dram_rdata = 32'h0000_005A;
        pulse(1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 3'd2);
        tick();
        clear_pulses();
        tick();
        chk("viol_busy", 32'(w_req_busy[1]), 32'd1);
        pulse(1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 3'd2);
        tick();
        clear_pulses();
        wait_rsp(1, cyc, ok);
        chk("viol_rsp", 32'(ok), 32'd1);
        repeat (10) tick();
        chk("viol_dram_cnt", 32'(dlog.size()), 32'd1);
        if (dlog.size() >= 1) chk("viol_dram_addr", dlog[0].addr, 32'h0000_0400);
        chk("viol_rsp_cnt", 32'(rsp_cnt[1] - snap1), 32'd1);
        chk("viol_odata1", w_rsp_odata[63:32], 32'h0000_005A);
        chk("viol_idle_busy", 32'(w_req_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
